cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl_if.sv | 26 ++
 rtl/cpu_clk_ctrl.sv | 111 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// CPU clock controller bundle: run/step/halt controls and divider select in, enables and status out.
// Latency: none (pure signal grouping).
// Backpressure: none; step_ack is the only handshake and is a one-clk pulse.
interface cpu_clk_ctrl_if;
   logic        run;
   logic        step_req;
   logic        halt_req;
   logic [3:0]  div_sel;
   logic        cpu_ce;
   logic        CPUCLK;
   logic        step_ack;
   logic [1:0]  state;
   logic [15:0] cycle_cnt;

   // Controller side of the bundle
   modport slave (
      input  run, step_req, halt_req, div_sel,
      output cpu_ce, CPUCLK, step_ack, state, cycle_cnt
   );

   // Driver side of the bundle (debug host / test environment)
   modport master (
      output run, step_req, halt_req, div_sel,
      input  cpu_ce, CPUCLK, step_ack, state, cycle_cnt
   );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator with HALT/RUN/STEP control and a programmable period of div_sel+1 clks.
// Latency: all outputs registered; first cpu_ce lands div_sel+1 clks after leaving HALT.
// Backpressure: none; step edges seen outside HALT are dropped, halt_req preempts everything.
module cpu_clk_ctrl (
   input  logic           clk,
   input  logic           rst,
   cpu_clk_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

   state_e      state_q,     state_d;
   logic [3:0]  div_cnt_q,   div_cnt_d;
   logic [3:0]  div_lat_q,   div_lat_d;
   logic        step_smp_q,  step_smp_d;
   logic        cpu_ce_q,    cpu_ce_d;
   logic        cpuclk_q,    cpuclk_d;
   logic        step_ack_q,  step_ack_d;
   logic [15:0] cycle_cnt_q, cycle_cnt_d;

   logic        step_edge;
   logic        boundary;

   // Next-state logic: halt_req wins, then run, then a fresh step_req edge
   always_comb begin
      step_edge   = bus.step_req & ~step_smp_q;
      boundary    = (div_cnt_q == div_lat_q);
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      div_lat_d   = div_lat_q;
      step_smp_d  = bus.step_req;
      cpu_ce_d    = 1'b0;
      step_ack_d  = 1'b0;

      if (bus.halt_req) begin
         // Pending boundary pulse is suppressed and any STEP is abandoned without ack
         state_d   = ST_HALT;
         div_cnt_d = 4'd0;
      end else begin
         case (state_q)
            ST_RUN, ST_STEP: begin
               if (boundary) begin
                  cpu_ce_d  = 1'b1;
                  div_cnt_d = 4'd0;
                  div_lat_d = bus.div_sel;
                  if (state_q == ST_STEP) begin
                     step_ack_d = 1'b1;
                     state_d    = ST_HALT;
                  end else if (!bus.run) begin
                     // run only takes effect once the current period has completed
                     state_d = ST_HALT;
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 4'd1;
               end
            end
            default: begin
               // HALT, and the unreachable 2'b11 code which behaves as HALT
               state_d   = ST_HALT;
               div_cnt_d = 4'd0;
               if (bus.run) begin
                  state_d   = ST_RUN;
                  div_lat_d = bus.div_sel;
               end else if (step_edge) begin
                  state_d   = ST_STEP;
                  div_lat_d = bus.div_sel;
               end
            end
         endcase
      end

      // CPUCLK follows the counter value that will be held in the coming cycle
      cpuclk_d    = ((state_d == ST_RUN) || (state_d == ST_STEP)) &&
                    (div_cnt_d <= (div_lat_d >> 1));
      cycle_cnt_d = cycle_cnt_q + {15'd0, cpu_ce_d};
   end

   // State and registered outputs; reset also clears outputs without waiting for a clk edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HALT;
         div_cnt_q   <= 4'd0;
         div_lat_q   <= 4'd0;
         step_smp_q  <= 1'b1;
         cpu_ce_q    <= 1'b0;
         cpuclk_q    <= 1'b0;
         step_ack_q  <= 1'b0;
         cycle_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         div_lat_q   <= div_lat_d;
         step_smp_q  <= step_smp_d;
         cpu_ce_q    <= cpu_ce_d;
         cpuclk_q    <= cpuclk_d;
         step_ack_q  <= step_ack_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign bus.cpu_ce    = cpu_ce_q;
   assign bus.CPUCLK    = cpuclk_q;
   assign bus.step_ack  = step_ack_q;
   assign bus.state     = state_q;
   assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed vector table, multi-cycle sequences, random run against a model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_cpu_clk_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   cpu_clk_ctrl_if bus ();

   cpu_clk_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       run;
      logic       step;
      logic       halt;
      logic [3:0] div;
      logic [1:0] st;
      logic       ce;
      logic       ack;
      logic       ck;
   } vec_t;

   vec_t tbl [21];

   // Reference model: remaining clks until the next pulse plus current period length
   int m_mode;   // 0 halted, 1 free run, 2 single step
   int m_left;
   int m_per;
   int m_prev;
   int m_cnt;
   int e_ce, e_ack, e_ck;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_per = 1; m_prev = 1; m_cnt = 0;
      e_ce = 0; e_ack = 0; e_ck = 0;
   endtask

   // Advance the model by one clk using the inputs present at the edge
   task automatic model_step();
      int edge_seen;
      edge_seen = (bus.step_req == 1'b1 && m_prev == 0) ? 1 : 0;
      m_prev    = int'(bus.step_req);
      e_ce = 0; e_ack = 0;
      if (bus.halt_req) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (bus.run || edge_seen == 1) begin
            m_mode = bus.run ? 1 : 2;
            m_per  = int'(bus.div_sel) + 1;
            m_left = m_per;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            e_ce  = 1;
            m_cnt = (m_cnt + 1) % 65536;
            if (m_mode == 2) begin
               e_ack  = 1;
               m_mode = 0;
            end else if (!bus.run) begin
               m_mode = 0;
            end else begin
               m_per  = int'(bus.div_sel) + 1;
               m_left = m_per;
            end
         end
      end
      if (m_mode == 0) e_ck = 0;
      else e_ck = ((m_per - m_left) <= ((m_per - 1) / 2)) ? 1 : 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.run = 1'b0; bus.step_req = 1'b0; bus.halt_req = 1'b0; bus.div_sel = 4'd0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_in(input logic r, input logic s, input logic h, input logic [3:0] d);
      bus.run = r; bus.step_req = s; bus.halt_req = h; bus.div_sel = d;
   endtask

   initial begin
      int n, pulses, acks, exp_cc;

      //             run  step  halt div   st     ce    ack   ck
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd2, 2'b10, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd2, 2'b10, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'd2, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'd2, 2'b00, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd1, 2'b01, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd1, 2'b01, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'b01, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'b01, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 4'd1, 2'b01, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{1'b1, 1'b1, 1'b0, 4'd3, 2'b01, 1'b0, 1'b0, 1'b1};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0};

      // Reset values while rst is held
      set_in(1'b1, 1'b1, 1'b0, 4'd3);
      #2;
      chk("rst_state",  32'(bus.state),     32'd0);
      chk("rst_ce",     32'(bus.cpu_ce),    32'd0);
      chk("rst_cpuclk", 32'(bus.CPUCLK),    32'd0);
      chk("rst_ack",    32'(bus.step_ack),  32'd0);
      chk("rst_cnt",    32'(bus.cycle_cnt), 32'd0);

      // Directed vector table, one row per clk
      do_reset();
      exp_cc = 0;
      for (int i = 0; i < 21; i++) begin
         set_in(tbl[i].run, tbl[i].step, tbl[i].halt, tbl[i].div);
         tick();
         if (tbl[i].ce) exp_cc++;
         chk($sformatf("tbl%0d_state", i),  32'(bus.state),     32'(tbl[i].st));
         chk($sformatf("tbl%0d_ce", i),     32'(bus.cpu_ce),    32'(tbl[i].ce));
         chk($sformatf("tbl%0d_ack", i),    32'(bus.step_ack),  32'(tbl[i].ack));
         chk($sformatf("tbl%0d_cpuclk", i), 32'(bus.CPUCLK),    32'(tbl[i].ck));
         chk($sformatf("tbl%0d_cnt", i),    32'(bus.cycle_cnt), 32'(exp_cc));
      end

      // Free run at div_sel=3: first pulse 4 clks after entry, then every 4th clk
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 4'd3);
      tick();
      chk("run_entry_state", 32'(bus.state), 32'd1);
      for (int p = 0; p < 5; p++) begin
         n = 0;
         do begin tick(); n++; end while (!bus.cpu_ce && n < 20);
         chk($sformatf("run_gap%0d", p), 32'(n), 32'd4);
      end
      chk("run_cnt5", 32'(bus.cycle_cnt), 32'd5);

      // Asynchronous reset in the middle of a run, observed before any clk edge
      tick(); tick();
      #2;
      chk("pre_rst_state", 32'(bus.state), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_state",  32'(bus.state),     32'd0);
      chk("async_rst_cpuclk", 32'(bus.CPUCLK),    32'd0);
      chk("async_rst_cnt",    32'(bus.cycle_cnt), 32'd0);
      chk("async_rst_ce",     32'(bus.cpu_ce),    32'd0);

      // step_req held high for 50 clks gives exactly one step
      do_reset();
      set_in(1'b0, 1'b0, 1'b0, 4'd2);
      tick();
      bus.step_req = 1'b1;
      pulses = 0; acks = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         pulses += int'(bus.cpu_ce);
         acks   += int'(bus.step_ack);
      end
      chk("hold_step_pulses", 32'(pulses), 32'd1);
      chk("hold_step_acks",   32'(acks),   32'd1);
      chk("hold_step_state",  32'(bus.state), 32'd0);
      chk("hold_step_cnt",    32'(bus.cycle_cnt), 32'd1);

      // run dropped at div_cnt=1 with div_sel=5: remaining pulse issues 5 clks later, then HALT
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 4'd5);
      tick();
      tick();
      bus.run = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!bus.cpu_ce && n < 20);
      chk("run_drop_delay", 32'(n), 32'd5);
      chk("run_drop_state", 32'(bus.state), 32'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         pulses += int'(bus.cpu_ce);
      end
      chk("run_drop_quiet", 32'(pulses), 32'd0);

      // Random stimulus against the model
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
         if ($urandom_range(0, 3) == 0)  bus.step_req = ~bus.step_req;
         bus.halt_req = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 7) == 0)  bus.div_sel = 4'($urandom_range(0, 15));
         @(posedge clk);
         model_step();
         #1;
         chk("rnd_state",  32'(bus.state),     32'(m_mode));
         chk("rnd_ce",     32'(bus.cpu_ce),    32'(e_ce));
         chk("rnd_ack",    32'(bus.step_ack),  32'(e_ack));
         chk("rnd_cpuclk", 32'(bus.CPUCLK),    32'(e_ck));
         chk("rnd_cnt",    32'(bus.cycle_cnt), 32'(m_cnt));
      end

      // cycle_cnt wrap: div_sel=0 pulses every clk until 0xFFFE, then 0xFFFF, then 0x0000
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 4'd0);
      n = 0;
      do begin tick(); n++; end while (bus.cycle_cnt != 16'hFFFE && n < 70000);
      chk("wrap_reach_fffe", 32'(bus.cycle_cnt), 32'h0000FFFE);
      chk("wrap_ce_high",    32'(bus.cpu_ce),    32'd1);
      chk("wrap_cpuclk",     32'(bus.CPUCLK),    32'd1);
      tick();
      chk("wrap_ffff", 32'(bus.cycle_cnt), 32'h0000FFFF);
      tick();
      chk("wrap_zero", 32'(bus.cycle_cnt), 32'h00000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
